// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg: shared state encoding, requester indices, ARID defaults and AXI constants.
package axi_rd_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10} state_t;
  typedef logic [3:0] axi_id_t;
  localparam int REQ_UNC = 0;
  localparam int REQ_DC = 1;
  localparam int REQ_IC = 2;
  localparam axi_id_t ID_UNC_DEF = 4'd2;
  localparam axi_id_t ID_DC_DEF = 4'd1;
  localparam axi_id_t ID_IC_DEF = 4'd0;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  function automatic logic [1:0] oh_idx(input logic [2:0] oh);
    return oh[REQ_IC] ? 2'd2 : oh[REQ_DC] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI read address/data channel bundle; master = arbiter side.
interface axi_rd_arbiter_if;
  import axi_rd_arbiter_pkg::*;
  axi_id_t arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  axi_id_t rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_prio_sel.sv
// axi_rd_prio_sel: one-hot grant, uncache > dcache > icache, aged icache overrides all.
module axi_rd_prio_sel
  import axi_rd_arbiter_pkg::*;
(
  input  logic [2:0] req_valid,
  input  logic       age_hit,
  output logic [2:0] grant
);
  assign grant = (age_hit && req_valid[REQ_IC]) ? 3'b100 :
                 req_valid[REQ_UNC] ? 3'b001 :
                 req_valid[REQ_DC]  ? 3'b010 :
                 req_valid[REQ_IC]  ? 3'b100 : 3'b000;
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: one-burst-at-a-time AXI read arbiter for uncache/dcache/icache requesters.
// Define AXI_RD_ERR_CHK_EN to enable sticky rd_err checking and overrun termination.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int      AGE_LIMIT = 15,
  parameter axi_id_t ID_UNC    = ID_UNC_DEF,
  parameter axi_id_t ID_DC     = ID_DC_DEF,
  parameter axi_id_t ID_IC     = ID_IC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   req_valid,
  input  logic [95:0]  req_addr,
  input  logic [23:0]  req_len,
  output logic [2:0]   req_ready,
  output logic [2:0]   rsp_valid,
  output logic         rsp_last,
  output logic [31:0]  rsp_data,
  output logic         rd_err,
  axi_rd_arbiter_if.master axi
);
  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);
  state_t state;
  logic [2:0] grant, sel;
  logic [3:0] age;
  logic [1:0] idx;
  logic beat, last;
  axi_rd_prio_sel u_sel (
    .req_valid(req_valid),
    .age_hit  (age == AGE_MAX),
    .grant    (sel)
  );
  assign idx = oh_idx(sel);
  assign beat = state == DATA && axi.rvalid;
  assign axi.arvalid = state == ADDR;
  assign axi.rready = state == DATA;
  assign axi.arsize = axi.arvalid ? AXI_SIZE_4B : '0;
  assign axi.arburst = axi.arvalid ? AXI_BURST_INCR : '0;
  assign rsp_valid = beat ? grant : '0;
  assign rsp_last = beat && last;
  assign rsp_data = beat ? axi.rdata : '0;
`ifdef AXI_RD_ERR_CHK_EN
  logic [7:0] beat_cnt;
  logic overrun, err_hit;
  // the beat that would push the count past arlen closes the burst itself
  assign overrun = beat_cnt == axi.arlen && !axi.rlast;
  assign last = axi.rlast || overrun;
  assign err_hit = beat && (axi.rresp != 2'b00 || axi.rid != axi.arid ||
                            (axi.rlast && beat_cnt != axi.arlen) || overrun);
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      rd_err <= 1'b0;
    end else begin
      beat_cnt <= (beat && last) ? '0 : beat ? beat_cnt + 8'd1 : beat_cnt;
      rd_err <= rd_err || err_hit;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp};
  assign last = axi.rlast;
  assign rd_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      age <= '0;
      req_ready <= '0;
      axi.arid <= '0;
      axi.araddr <= '0;
      axi.arlen <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          age <= (!req_valid[REQ_IC] || sel[REQ_IC]) ? '0 : (age == AGE_MAX) ? age : age + 4'd1;
          if (|sel) begin
            grant <= sel;
            axi.araddr <= req_addr[{idx, 5'd0} +: 32];
            axi.arlen <= req_len[{idx, 3'd0} +: 8];
            axi.arid <= sel[REQ_UNC] ? ID_UNC : sel[REQ_DC] ? ID_DC : ID_IC;
            state <= ADDR;
          end
        end
        ADDR: if (axi.arready) begin
          req_ready <= grant;
          state <= DATA;
        end
        DATA: if (beat && last) begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed self-checking bench with immediate assertions per comparison.
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] req_valid = '0;
  logic [95:0] req_addr = '0;
  logic [23:0] req_len = '0;
  logic [2:0] req_ready, rsp_valid;
  logic rsp_last, rd_err;
  logic [31:0] rsp_data;
  int n_chk = 0;
  int n_fail = 0;
`ifdef AXI_RD_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  axi_rd_arbiter_if axi();
  axi_rd_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_last(rsp_last), .rsp_data(rsp_data), .rd_err(rd_err), .axi(axi)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l);
    req_addr[i*32 +: 32] = a;
    req_len[i*8 +: 8] = l;
    req_valid[i] = 1'b1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  // from an IDLE cycle: expect this grant, complete the AR handshake, deliver len+1 beats
  task automatic serve(input logic [2:0] g, input logic [31:0] a, input logic [7:0] l,
                       input logic [3:0] id, input logic [31:0] dbase, input bit gap);
    int b = 0;
    int c = 0;
    chk("bubble_arvalid", 32'(axi.arvalid), 0);
    step();
    chk("arvalid", 32'(axi.arvalid), 1);
    chk("araddr", axi.araddr, a);
    chk("arlen", 32'(axi.arlen), 32'(l));
    chk("arid", 32'(axi.arid), 32'(id));
    chk("arsize", 32'(axi.arsize), 2);
    chk("arburst", 32'(axi.arburst), 1);
    chk("req_ready_early", 32'(req_ready), 0);
    step();
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("arvalid_drop", 32'(axi.arvalid), 0);
    chk("rready", 32'(axi.rready), 1);
    req_valid = req_valid & ~g;
    while (b <= int'(l)) begin
      if (gap && c % 3 == 2) begin
        axi.rvalid = 1'b0;
        #1;
        chk("gap_rsp_valid", 32'(rsp_valid), 0);
      end else begin
        axi.rvalid = 1'b1;
        axi.rdata = dbase + 32'(b);
        axi.rlast = b == int'(l);
        axi.rid = id;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(g));
        chk("rsp_data", rsp_data, dbase + 32'(b));
        chk("rsp_last", 32'(rsp_last), 32'(b == int'(l)));
        b++;
      end
      c++;
      step();
    end
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
    #1;
    chk("end_rready", 32'(axi.rready), 0);
    chk("end_rsp_valid", 32'(rsp_valid), 0);
    chk("end_req_ready", 32'(req_ready), 0);
  endtask
  initial begin
    axi.arready = 1'b1;
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
    axi.rdata = '0;
    axi.rid = '0;
    axi.rresp = '0;
    reset = 1'b1;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_last", 32'(rsp_last), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    chk("rst_arvalid", 32'(axi.arvalid), 0);
    chk("rst_rready", 32'(axi.rready), 0);
    chk("rst_araddr", axi.araddr, 0);
    reset = 1'b0;
    step();
    // single uncache read
    set_req(0, 32'h1FC0_0000, 8'd0);
    serve(3'b001, 32'h1FC0_0000, 8'd0, 4'd2, 32'hDEADBEEF, 1'b0);
    // dcache 16-beat refill with rvalid gaps
    set_req(1, 32'h0000_1000, 8'd15);
    serve(3'b010, 32'h0000_1000, 8'd15, 4'd1, 32'h0000_0100, 1'b1);
    // all three at once: uncache, dcache, icache
    set_req(0, 32'hA000_0000, 8'd0);
    set_req(1, 32'hB000_0040, 8'd1);
    set_req(2, 32'hC000_0080, 8'd2);
    serve(3'b001, 32'hA000_0000, 8'd0, 4'd2, 32'h1000, 1'b0);
    serve(3'b010, 32'hB000_0040, 8'd1, 4'd1, 32'h2000, 1'b0);
    serve(3'b100, 32'hC000_0080, 8'd2, 4'd0, 32'h3000, 1'b0);
    // starvation: icache held, dcache re-requests every IDLE
    set_req(2, 32'hC000_0100, 8'd0);
    for (int i = 0; i < 15; i++) begin
      set_req(1, 32'hB000_0000 + 32'(i * 64), 8'd0);
      serve(3'b010, 32'hB000_0000 + 32'(i * 64), 8'd0, 4'd1, 32'h4000, 1'b0);
    end
    set_req(1, 32'hB000_1000, 8'd0);
    serve(3'b100, 32'hC000_0100, 8'd0, 4'd0, 32'h5000, 1'b0);
    chk("age_cleared", 32'(dut.age), 0);
    serve(3'b010, 32'hB000_1000, 8'd0, 4'd1, 32'h6000, 1'b0);
    // reset at beat 5 of a 16-beat dcache burst
    set_req(1, 32'h0000_2000, 8'd15);
    step();
    step();
    chk("rst_burst_req_ready", 32'(req_ready), 3'b010);
    req_valid = '0;
    for (int b = 0; b < 5; b++) begin
      axi.rvalid = 1'b1;
      axi.rdata = 32'(b);
      axi.rid = 4'd1;
      step();
    end
    reset = 1'b1;
    #1;
    chk("beat5_rsp_valid", 32'(rsp_valid), 3'b010);
    step();
    chk("midrst_rready", 32'(axi.rready), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_arvalid", 32'(axi.arvalid), 0);
    reset = 1'b0;
    axi.rvalid = 1'b0;
    step();
    // rid mismatch and SLVERR: beat still delivered
    set_req(0, 32'h1FC0_0040, 8'd0);
    step();
    step();
    req_valid = '0;
    axi.rvalid = 1'b1;
    axi.rlast = 1'b1;
    axi.rid = 4'd7;
    axi.rresp = 2'b10;
    axi.rdata = 32'h5555_AAAA;
    #1;
    chk("mis_rsp_valid", 32'(rsp_valid), 3'b001);
    chk("mis_rsp_data", rsp_data, 32'h5555_AAAA);
    chk("mis_rsp_last", 32'(rsp_last), 1);
    step();
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
    axi.rresp = 2'b00;
    chk("mis_rd_err", 32'(rd_err), 32'(ERR_EN));
    chk("mis_rready", 32'(axi.rready), 0);
    step();
    chk("mis_rd_err_held", 32'(rd_err), 32'(ERR_EN));
`ifdef AXI_RD_ERR_CHK_EN
    // early rlast on beat 8 of a 16-beat burst
    do_reset();
    chk("err_rst_clear", 32'(rd_err), 0);
    set_req(1, 32'h0000_3000, 8'd15);
    step();
    step();
    req_valid = '0;
    for (int b = 0; b < 8; b++) begin
      axi.rvalid = 1'b1;
      axi.rid = 4'd1;
      axi.rlast = b == 7;
      #1;
      chk("early_rsp_last", 32'(rsp_last), 32'(b == 7));
      step();
    end
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
    chk("early_rd_err", 32'(rd_err), 1);
    chk("early_rready", 32'(axi.rready), 0);
    step();
    chk("early_rd_err_held", 32'(rd_err), 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
